// File: rtl/pattern_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_sequencer_if
//  Brief    : Control/status bundle between the pattern sequencer and its user.
//  Revision : 1.0  initial release
// ============================================================================
interface pattern_sequencer_if #(
    parameter int SEQ_W  = 6,
    parameter int STEP_W = 4
);
    logic                    step_en;
    logic                    seq_up;
    logic                    seq_dn;
    logic [1:0]              mode;
    logic                    restart;
    logic [SEQ_W+STEP_W-1:0] rom_addr;
    logic [SEQ_W-1:0]        seq_num;
    logic [STEP_W-1:0]       step_idx;
    logic                    wrap;
    logic                    done;

    modport master (
        output step_en, seq_up, seq_dn, mode, restart,
        input  rom_addr, seq_num, step_idx, wrap, done
    );

    modport slave (
        input  step_en, seq_up, seq_dn, mode, restart,
        output rom_addr, seq_num, step_idx, wrap, done
    );
endinterface
`default_nettype wire

// File: rtl/pattern_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_sequencer
//  Brief    : Button-selected LED pattern stepper producing the pattern ROM
//             address; loop, ping-pong, one-shot and pause stepping modes.
//  Revision : 1.0  initial release
// ============================================================================
module pattern_sequencer #(
    parameter int SEQ_W    = 6,
    parameter int STEP_W   = 4,
    parameter int NUM_SEQ  = 64,
    parameter int SEQ_WRAP = 1
) (
    input  wire logic          CLK_50,
    input  wire logic          reset_n,
    pattern_sequencer_if.slave bus
);
    typedef enum logic [0:0] {
        DIR_FWD = 1'b0,
        DIR_REV = 1'b1
    } dir_t;

    localparam logic [SEQ_W-1:0]  c_SEQ_MAX  = SEQ_W'(NUM_SEQ - 1);
    localparam logic [STEP_W-1:0] c_STEP_MAX = {STEP_W{1'b1}};
    localparam logic [1:0]        c_MODE_LOOP = 2'b00;
    localparam logic [1:0]        c_MODE_PING = 2'b01;
    localparam logic [1:0]        c_MODE_ONE  = 2'b10;

    logic [SEQ_W-1:0]        r_seq;
    logic [STEP_W-1:0]       r_step;
    dir_t                    r_dir;
    logic                    r_done;
    logic                    r_wrap;
    logic [SEQ_W+STEP_W-1:0] r_rom_addr;
    logic                    r_up_prev;
    logic                    r_dn_prev;
    logic                    r_armed;

    logic                    w_up_edge;
    logic                    w_dn_edge;
    logic [SEQ_W-1:0]        w_seq_nxt;
    logic [STEP_W-1:0]       w_step_nxt;
    dir_t                    w_dir_nxt;
    logic                    w_done_nxt;
    logic                    w_wrap_nxt;

    // r_armed masks the first clock after reset so a held button gives no edge
    assign w_up_edge = r_armed & bus.seq_up & ~r_up_prev;
    assign w_dn_edge = r_armed & bus.seq_dn & ~r_dn_prev;

    always_comb begin
        w_seq_nxt  = r_seq;
        w_step_nxt = r_step;
        w_dir_nxt  = r_dir;
        w_done_nxt = r_done;
        w_wrap_nxt = 1'b0;

        if (w_up_edge ^ w_dn_edge) begin
            if (w_up_edge) begin
                if (r_seq == c_SEQ_MAX)
                    w_seq_nxt = (SEQ_WRAP != 0) ? '0 : r_seq;
                else
                    w_seq_nxt = r_seq + SEQ_W'(1);
            end else begin
                if (r_seq == '0)
                    w_seq_nxt = (SEQ_WRAP != 0) ? c_SEQ_MAX : r_seq;
                else
                    w_seq_nxt = r_seq - SEQ_W'(1);
            end
            w_step_nxt = '0;
            w_dir_nxt  = DIR_FWD;
            w_done_nxt = 1'b0;
        end else if (bus.restart) begin
            w_step_nxt = '0;
            w_dir_nxt  = DIR_FWD;
            w_done_nxt = 1'b0;
        end else if (bus.step_en) begin
            case (bus.mode)
                c_MODE_LOOP: begin
                    w_dir_nxt  = DIR_FWD;
                    w_step_nxt = r_step + STEP_W'(1);
                    w_wrap_nxt = (r_step == c_STEP_MAX);
                end
                c_MODE_PING: begin
                    if (r_dir == DIR_FWD) begin
                        // Entering at the top end (e.g. from loop mode) turns around immediately
                        if (r_step == c_STEP_MAX) begin
                            w_step_nxt = c_STEP_MAX - STEP_W'(1);
                            w_dir_nxt  = DIR_REV;
                        end else begin
                            w_step_nxt = r_step + STEP_W'(1);
                            if (r_step == c_STEP_MAX - STEP_W'(1))
                                w_dir_nxt = DIR_REV;
                        end
                    end else begin
                        if (r_step == '0) begin
                            w_step_nxt = STEP_W'(1);
                            w_dir_nxt  = DIR_FWD;
                        end else begin
                            w_step_nxt = r_step - STEP_W'(1);
                            if (r_step == STEP_W'(1)) begin
                                w_dir_nxt  = DIR_FWD;
                                w_wrap_nxt = 1'b1;
                            end
                        end
                    end
                end
                c_MODE_ONE: begin
                    w_dir_nxt = DIR_FWD;
                    if (r_step != c_STEP_MAX) begin
                        w_step_nxt = r_step + STEP_W'(1);
                    end else if (!r_done) begin
                        w_done_nxt = 1'b1;
                        w_wrap_nxt = 1'b1;
                    end
                end
                default: begin
                    w_step_nxt = r_step;
                end
            endcase
        end
    end

    always_ff @(posedge CLK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_seq      <= '0;
            r_step     <= '0;
            r_dir      <= DIR_FWD;
            r_done     <= 1'b0;
            r_wrap     <= 1'b0;
            r_rom_addr <= '0;
            r_up_prev  <= 1'b0;
            r_dn_prev  <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_seq      <= w_seq_nxt;
            r_step     <= w_step_nxt;
            r_dir      <= w_dir_nxt;
            r_done     <= w_done_nxt;
            r_wrap     <= w_wrap_nxt;
            r_rom_addr <= {w_seq_nxt, w_step_nxt};
            r_up_prev  <= bus.seq_up;
            r_dn_prev  <= bus.seq_dn;
            r_armed    <= 1'b1;
        end
    end

    assign bus.seq_num  = r_seq;
    assign bus.step_idx = r_step;
    assign bus.done     = r_done;
    assign bus.wrap     = r_wrap;
    assign bus.rom_addr = r_rom_addr;
endmodule
`default_nettype wire
